// File: rtl/vga_pkg.sv
// vga_pkg
// Shared raster constants for the 1280x1024@60 VGA output (108 MHz pixel clock).
// Holds the horizontal/vertical timing, the counter widths used on the raster
// bus and the renderer latency that the sync outputs have to be aligned to.
// No ports; imported or referenced by scope from the timing generator.
package vga_pkg;

   localparam int H_ACTIVE = 1280;
   localparam int H_FP     = 48;
   localparam int H_SYNC   = 112;
   localparam int H_BP     = 248;
   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

   localparam int V_ACTIVE = 1024;
   localparam int V_FP     = 1;
   localparam int V_SYNC   = 3;
   localparam int V_BP     = 38;
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam int COL_W   = 12;
   localparam int ROW_W   = 11;
   localparam int FRAME_W = 8;

   // Renderer RGB latency: one cycle of sprite RAM read plus one output register.
   localparam int RENDER_LATENCY = 2;
   localparam int MAX_SYNC_DELAY = 7;

endpackage

// File: rtl/sync_delay_line.sv
// sync_delay_line
// Enable-qualified shift register that carries the hsync/vsync pair so the
// syncs leave the chip on the same pixel as the renderer's RGB.
// Ports:
//   clock  in   pixel clock, rising edge
//   reset  in   synchronous active-low reset, loads every stage with INIT
//   en_i   in   shift enable (pixel enable); stages hold while low
//   d_i    in   2-bit sync pair {hs, vs} entering the line
//   q_o    out  2-bit sync pair after DEPTH enabled stages (DEPTH=0 passes through)
module sync_delay_line #(
   parameter int         DEPTH = 2,
   parameter logic [1:0] INIT  = 2'b00
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       en_i,
   input  logic [1:0] d_i,
   output logic [1:0] q_o
);

   if (DEPTH < 0 || DEPTH > vga_pkg::MAX_SYNC_DELAY) begin : g_badDepth
      $error("sync_delay_line: DEPTH %0d outside 0..%0d", DEPTH, vga_pkg::MAX_SYNC_DELAY);
   end

   if (DEPTH == 0) begin : g_bypass
      assign q_o = d_i;
   end else begin : g_stages
      logic [1:0] stage_q [DEPTH];

      // Shift one stage per enabled clock; reset puts the inactive sync level in
      // every stage so no stale pulse can emerge after reset is released.
      always_ff @(posedge clock) begin
         if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
               stage_q[i] <= INIT;
            end
         end else if (en_i) begin
            stage_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
               stage_q[i] <= stage_q[i-1];
            end
         end
      end

      assign q_o = stage_q[DEPTH-1];
   end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// Raster timing source for the VGA output. An internal pixel/line counter pair
// scans the frame; a registered output stage presents the position, the
// visible flag and the raw syncs together, and the syncs then pass through a
// short delay line so they line up with the renderer's RGB pipeline.
// Ports:
//   clock        in   pixel clock, rising edge
//   reset        in   synchronous active-low reset
//   pix_en       in   advance enable; everything holds while low
//   display_col  out  current column, 0..H_TOTAL-1
//   display_row  out  current line, 0..V_TOTAL-1
//   visible      out  high inside the active picture
//   hsync        out  horizontal sync, polarity SYNC_POS, delayed SYNC_DELAY
//   vsync        out  vertical sync, polarity SYNC_POS, delayed SYNC_DELAY
//   frame_start  out  single pix_en-cycle pulse while the position is (0,0)
//   frame_count  out  completed-frame counter, wraps 255->0
module vga_timing_gen #(
   parameter int H_ACTIVE   = vga_pkg::H_ACTIVE,
   parameter int H_FP       = vga_pkg::H_FP,
   parameter int H_SYNC     = vga_pkg::H_SYNC,
   parameter int H_BP       = vga_pkg::H_BP,
   parameter int V_ACTIVE   = vga_pkg::V_ACTIVE,
   parameter int V_FP       = vga_pkg::V_FP,
   parameter int V_SYNC     = vga_pkg::V_SYNC,
   parameter int V_BP       = vga_pkg::V_BP,
   parameter int SYNC_POS   = 1,
   parameter int SYNC_DELAY = vga_pkg::RENDER_LATENCY
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          pix_en,
   output logic [vga_pkg::COL_W-1:0]     display_col,
   output logic [vga_pkg::ROW_W-1:0]     display_row,
   output logic                          visible,
   output logic                          hsync,
   output logic                          vsync,
   output logic                          frame_start,
   output logic [vga_pkg::FRAME_W-1:0]   frame_count
);

   localparam int COL_W   = vga_pkg::COL_W;
   localparam int ROW_W   = vga_pkg::ROW_W;
   localparam int FRAME_W = vga_pkg::FRAME_W;

   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HS_START = H_ACTIVE + H_FP;
   localparam int HS_END   = HS_START + H_SYNC;
   localparam int VS_START = V_ACTIVE + V_FP;
   localparam int VS_END   = VS_START + V_SYNC;

   localparam logic [COL_W-1:0] H_LAST = COL_W'(H_TOTAL - 1);
   localparam logic [ROW_W-1:0] V_LAST = ROW_W'(V_TOTAL - 1);

   localparam logic       SYNC_IDLE      = (SYNC_POS == 0);
   localparam logic [1:0] SYNC_IDLE_PAIR = {SYNC_IDLE, SYNC_IDLE};

   if (H_TOTAL - 1 >= (1 << COL_W)) begin : g_badHTotal
      $error("vga_timing_gen: H_TOTAL-1 (%0d) does not fit in %0d bits", H_TOTAL - 1, COL_W);
   end
   if (V_TOTAL - 1 >= (1 << ROW_W)) begin : g_badVTotal
      $error("vga_timing_gen: V_TOTAL-1 (%0d) does not fit in %0d bits", V_TOTAL - 1, ROW_W);
   end
   if (SYNC_DELAY < 0 || SYNC_DELAY > vga_pkg::MAX_SYNC_DELAY) begin : g_badDelay
      $error("vga_timing_gen: SYNC_DELAY %0d outside 0..%0d", SYNC_DELAY, vga_pkg::MAX_SYNC_DELAY);
   end

   logic [COL_W-1:0]   h_q, h_d;
   logic [ROW_W-1:0]   v_q, v_d;
   logic [FRAME_W-1:0] fc_q, fc_d;

   logic [COL_W-1:0]   col_q;
   logic [ROW_W-1:0]   row_q;
   logic [FRAME_W-1:0] fcOut_q;
   logic               visible_q, visible_d;
   logic               fs_q, fs_d;
   logic [1:0]         rawSync_q, rawSync_d;
   logic [1:0]         syncOut;

   logic hWrap, vLast, hsActive, vsActive;

   // Next counter position plus the decode of the current position. The decode
   // is taken from the counters, then registered alongside the position copy,
   // so column, row, visible and raw syncs always describe the same pixel.
   always_comb begin
      hWrap    = (h_q == H_LAST);
      vLast    = (v_q == V_LAST);
      h_d      = hWrap ? '0 : h_q + 1'b1;
      v_d      = v_q;
      fc_d     = fc_q;
      if (hWrap) begin
         v_d = vLast ? '0 : v_q + 1'b1;
         if (vLast) begin
            fc_d = fc_q + 1'b1;
         end
      end
      hsActive  = (int'(h_q) >= HS_START) && (int'(h_q) < HS_END);
      vsActive  = (int'(v_q) >= VS_START) && (int'(v_q) < VS_END);
      visible_d = (int'(h_q) < H_ACTIVE) && (int'(v_q) < V_ACTIVE);
      fs_d      = (h_q == '0) && (v_q == '0);
      rawSync_d = {hsActive ^ SYNC_IDLE, vsActive ^ SYNC_IDLE};
   end

   // Counter stage and registered output stage advance together on pix_en.
   // Reset returns the counters to (0,0) and parks the outputs in the blank,
   // sync-inactive state; the first enabled clock afterwards presents (0,0).
   always_ff @(posedge clock) begin
      if (!reset) begin
         h_q       <= '0;
         v_q       <= '0;
         fc_q      <= '0;
         col_q     <= '0;
         row_q     <= '0;
         fcOut_q   <= '0;
         visible_q <= 1'b0;
         fs_q      <= 1'b0;
         rawSync_q <= SYNC_IDLE_PAIR;
      end else if (pix_en) begin
         h_q       <= h_d;
         v_q       <= v_d;
         fc_q      <= fc_d;
         col_q     <= h_q;
         row_q     <= v_q;
         fcOut_q   <= fc_q;
         visible_q <= visible_d;
         fs_q      <= fs_d;
         rawSync_q <= rawSync_d;
      end
   end

   // Syncs are delayed to match the renderer's RGB latency.
   sync_delay_line #(
      .DEPTH (SYNC_DELAY),
      .INIT  (SYNC_IDLE_PAIR)
   ) u_syncDelay (
      .clock (clock),
      .reset (reset),
      .en_i  (pix_en),
      .d_i   (rawSync_q),
      .q_o   (syncOut)
   );

   assign display_col = col_q;
   assign display_row = row_q;
   assign visible     = visible_q;
   assign hsync       = syncOut[1];
   assign vsync       = syncOut[0];
   assign frame_count = fcOut_q;

   // A held (0,0) position must not look like a second frame start to
   // downstream logic, so the pulse is masked by the live enable.
   assign frame_start = fs_q & pix_en;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen
// Drives two generators from one clock/reset/pix_en: a shrunken-raster build
// (so whole frames and the frame counter wrap fit in a short run) and the
// full 1280x1024 build with active-low syncs. Every sample is compared with a
// position-based reference computed from the raster arithmetic.
module tb_vga_timing_gen;

   localparam int S_HA = 6, S_HFP = 1, S_HSW = 2, S_HBP = 3;
   localparam int S_VA = 3, S_VFP = 1, S_VSW = 2, S_VBP = 1;
   localparam int S_DLY = 2;
   localparam int S_HT = S_HA + S_HFP + S_HSW + S_HBP;
   localparam int S_VT = S_VA + S_VFP + S_VSW + S_VBP;

   localparam int D_HA = 1280, D_HFP = 48, D_HSW = 112, D_HBP = 248;
   localparam int D_VA = 1024, D_VFP = 1,  D_VSW = 3,   D_VBP = 38;
   localparam int D_DLY = 2;
   localparam int D_HT = D_HA + D_HFP + D_HSW + D_HBP;

   typedef struct packed {
      logic [11:0] col;
      logic [10:0] row;
      logic        vis;
      logic        hs;
      logic        vs;
      logic        fs;
      logic [7:0]  fc;
   } snap_t;

   logic clock  = 1'b0;
   logic reset  = 1'b0;
   logic pix_en = 1'b0;

   logic [11:0] colS, colD;
   logic [10:0] rowS, rowD;
   logic        visS, visD, hsS, hsD, vsS, vsD, fsS, fsD;
   logic [7:0]  fcS, fcD;

   snap_t obsS, obsD;
   assign obsS = {colS, rowS, visS, hsS, vsS, fsS, fcS};
   assign obsD = {colD, rowD, visD, hsD, vsD, fsD, fcD};

   longint steps = 0;
   int vectors     = 0;
   int miscompares = 0;

   always #5 clock = ~clock;

   vga_timing_gen #(
      .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HSW), .H_BP(S_HBP),
      .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VSW), .V_BP(S_VBP),
      .SYNC_POS(1), .SYNC_DELAY(S_DLY)
   ) dutS (
      .clock(clock), .reset(reset), .pix_en(pix_en),
      .display_col(colS), .display_row(rowS), .visible(visS),
      .hsync(hsS), .vsync(vsS), .frame_start(fsS), .frame_count(fcS)
   );

   vga_timing_gen #(
      .SYNC_POS(0)
   ) dutD (
      .clock(clock), .reset(reset), .pix_en(pix_en),
      .display_col(colD), .display_row(rowD), .visible(visD),
      .hsync(hsD), .vsync(vsD), .frame_start(fsD), .frame_count(fcD)
   );

   // Number of enabled clocks since the last reset edge.
   always @(posedge clock) begin
      if (!reset) steps <= 0;
      else if (pix_en) steps <= steps + 1;
   end

   // Reference: after m enabled clocks the outputs show raster position m-1
   // (m=0 is the parked reset state); syncs show the raster position dly
   // enabled clocks earlier.
   function automatic snap_t model(input int ha, input int hfp, input int hsw, input int hbp,
                                   input int va, input int vfp, input int vsw, input int vbp,
                                   input bit spos, input int dly, input longint m, input logic pe);
      snap_t  e;
      longint ht, vt, pos, p2, c, r, c2, r2;
      logic   idle;
      ht   = ha + hfp + hsw + hbp;
      vt   = va + vfp + vsw + vbp;
      idle = ~spos;
      e    = '0;
      e.hs = idle;
      e.vs = idle;
      if (m > 0) begin
         pos   = m - 1;
         c     = pos % ht;
         r     = (pos / ht) % vt;
         e.col = 12'(c);
         e.row = 11'(r);
         e.fc  = 8'((pos / (ht * vt)) % 256);
         e.vis = (c < ha) && (r < va);
         e.fs  = (c == 0) && (r == 0) && (pe === 1'b1);
         p2    = pos - dly;
         if (p2 >= 0) begin
            c2 = p2 % ht;
            r2 = (p2 / ht) % vt;
            if (c2 >= ha + hfp && c2 < ha + hfp + hsw) e.hs = ~idle;
            if (r2 >= va + vfp && r2 < va + vfp + vsw) e.vs = ~idle;
         end
      end
      return e;
   endfunction

   function automatic snap_t expSmall();
      return model(S_HA, S_HFP, S_HSW, S_HBP, S_VA, S_VFP, S_VSW, S_VBP, 1'b1, S_DLY, steps, pix_en);
   endfunction

   function automatic snap_t expDefault();
      return model(D_HA, D_HFP, D_HSW, D_HBP, D_VA, D_VFP, D_VSW, D_VBP, 1'b0, D_DLY, steps, pix_en);
   endfunction

   task automatic applyStimulus(input logic rst, input logic pe);
      @(posedge clock);
      #1;
      reset  = rst;
      pix_en = pe;
      @(negedge clock);
   endtask

   task automatic test_reset();
      snap_t firstS, firstD;
      firstS = {12'd0, 11'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0};
      firstD = {12'd0, 11'd0, 1'b1, 1'b1, 1'b1, 1'b1, 8'd0};
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b0, 1'b1);
         vectors++;
         if (obsS !== expSmall()) begin
            miscompares++;
            $display("[TB] FAIL reset_small: got %h expected %h", obsS, expSmall());
         end
         vectors++;
         if (obsD !== expDefault()) begin
            miscompares++;
            $display("[TB] FAIL reset_default: got %h expected %h", obsD, expDefault());
         end
      end
      applyStimulus(1'b1, 1'b1);
      applyStimulus(1'b1, 1'b1);
      vectors++;
      if (obsS !== firstS) begin
         miscompares++;
         $display("[TB] FAIL first_cycle_small: got %h expected %h", obsS, firstS);
      end
      vectors++;
      if (obsD !== firstD) begin
         miscompares++;
         $display("[TB] FAIL first_cycle_default: got %h expected %h", obsD, firstD);
      end
   endtask

   task automatic test_line();
      int hsCount  = 0;
      int firstCol = -1;
      for (int i = 0; i < 2 * D_HT; i++) begin
         applyStimulus(1'b1, 1'b1);
         vectors++;
         if (obsS !== expSmall()) begin
            miscompares++;
            $display("[TB] FAIL line_small: got %h expected %h", obsS, expSmall());
         end
         vectors++;
         if (obsD !== expDefault()) begin
            miscompares++;
            $display("[TB] FAIL line_default: got %h expected %h", obsD, expDefault());
         end
         if (hsD === 1'b0) begin
            hsCount++;
            if (firstCol < 0) firstCol = int'(colD);
         end
      end
      vectors++;
      if (hsCount !== 2 * 112) begin
         miscompares++;
         $display("[TB] FAIL hsync_width: got %0d cycles expected %0d", hsCount, 2 * 112);
      end
      vectors++;
      if (firstCol !== 1330) begin
         miscompares++;
         $display("[TB] FAIL hsync_start_col: got %0d expected %0d", firstCol, 1330);
      end
   endtask

   task automatic test_pix_en_toggle();
      for (int i = 0; i < 2 * D_HT; i++) begin
         applyStimulus(1'b1, (i % 2 == 0) ? 1'b1 : 1'b0);
         vectors++;
         if (obsS !== expSmall()) begin
            miscompares++;
            $display("[TB] FAIL toggle_small: got %h expected %h", obsS, expSmall());
         end
         vectors++;
         if (obsD !== expDefault()) begin
            miscompares++;
            $display("[TB] FAIL toggle_default: got %h expected %h", obsD, expDefault());
         end
         if (pix_en === 1'b0) begin
            vectors++;
            if (fsS !== 1'b0) begin
               miscompares++;
               $display("[TB] FAIL frame_start_held: got %b expected 0", fsS);
            end
         end
      end
   endtask

   task automatic test_frame_wrap();
      logic [7:0] prevFc  = fcS;
      bit         sawWrap = 1'b0;
      for (int i = 0; i < 257 * S_HT * S_VT; i++) begin
         applyStimulus(1'b1, 1'b1);
         vectors++;
         if (obsS !== expSmall()) begin
            miscompares++;
            $display("[TB] FAIL frame_small: got %h expected %h", obsS, expSmall());
         end
         vectors++;
         if (obsD !== expDefault()) begin
            miscompares++;
            $display("[TB] FAIL frame_default: got %h expected %h", obsD, expDefault());
         end
         if (prevFc === 8'd255 && fcS === 8'd0) sawWrap = 1'b1;
         prevFc = fcS;
      end
      vectors++;
      if (sawWrap !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL frame_count_wrap: got %b expected 1", sawWrap);
      end
   endtask

   task automatic test_reset_midframe();
      snap_t firstS;
      firstS = {12'd0, 11'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0};
      for (int t = 0; t < 4; t++) begin
         int runLen = $urandom_range(50, 400);
         for (int i = 0; i < runLen; i++) begin
            applyStimulus(1'b1, 1'($urandom_range(0, 3) != 0));
            vectors++;
            if (obsS !== expSmall()) begin
               miscompares++;
               $display("[TB] FAIL midframe_run_small: got %h expected %h", obsS, expSmall());
            end
         end
         applyStimulus(1'b0, 1'b1);
         applyStimulus(1'b1, 1'b1);
         vectors++;
         if (obsS !== expSmall()) begin
            miscompares++;
            $display("[TB] FAIL midframe_reset_small: got %h expected %h", obsS, expSmall());
         end
         vectors++;
         if (obsD !== expDefault()) begin
            miscompares++;
            $display("[TB] FAIL midframe_reset_default: got %h expected %h", obsD, expDefault());
         end
         applyStimulus(1'b1, 1'b1);
         vectors++;
         if (obsS !== firstS) begin
            miscompares++;
            $display("[TB] FAIL midframe_restart: got %h expected %h", obsS, firstS);
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 3000; i++) begin
         applyStimulus(1'($urandom_range(0, 399) != 0), 1'($urandom_range(0, 9) < 7));
         vectors++;
         if (obsS !== expSmall()) begin
            miscompares++;
            $display("[TB] FAIL random_small: got %h expected %h", obsS, expSmall());
         end
         vectors++;
         if (obsD !== expDefault()) begin
            miscompares++;
            $display("[TB] FAIL random_default: got %h expected %h", obsD, expDefault());
         end
      end
   endtask

   initial begin
      test_reset();
      test_line();
      test_pix_en_toggle();
      test_frame_wrap();
      test_reset_midframe();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
